seg_scan_capture: RTL

//  Listening end of the 4-digit multiplexed 7-segment display bus (SEG_D1..SEG_D4, SEG_A..SEG_G, SEG_P).

---
 rtl/seg_scan_pkg.sv | 33 +++
 rtl/seg7_to_hex.sv | 39 +++
 rtl/seg_scan_capture.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan capture block.
// Segment patterns are normalised (1 = lit), bit order {g,f,e,d,c,b,a}.
package seg_scan_pkg;

    localparam logic [6:0] SEG_PAT_0     = 7'h3F;
    localparam logic [6:0] SEG_PAT_1     = 7'h06;
    localparam logic [6:0] SEG_PAT_2     = 7'h5B;
    localparam logic [6:0] SEG_PAT_3     = 7'h4F;
    localparam logic [6:0] SEG_PAT_4     = 7'h66;
    localparam logic [6:0] SEG_PAT_5     = 7'h6D;
    localparam logic [6:0] SEG_PAT_6     = 7'h7D;
    localparam logic [6:0] SEG_PAT_7     = 7'h07;
    localparam logic [6:0] SEG_PAT_8     = 7'h7F;
    localparam logic [6:0] SEG_PAT_9     = 7'h6F;
    localparam logic [6:0] SEG_PAT_A     = 7'h77;
    localparam logic [6:0] SEG_PAT_B     = 7'h7C;
    localparam logic [6:0] SEG_PAT_C     = 7'h39;
    localparam logic [6:0] SEG_PAT_D     = 7'h5E;
    localparam logic [6:0] SEG_PAT_E     = 7'h79;
    localparam logic [6:0] SEG_PAT_F     = 7'h71;
    localparam logic [6:0] SEG_PAT_BLANK = 7'h00;

    // Digit index: 0 = SEG_D1 ... 3 = SEG_D4.
    typedef logic [1:0] dig_idx_t;

    // How many digit strobes are active in one registered sample.
    typedef enum logic [1:0] {
        STB_NONE,
        STB_ONE,
        STB_MULTI
    } strobe_kind_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder: normalised 7-segment pattern to hex nibble.
// is_legal_o marks one of the 16 hex glyphs; is_blank_o marks all segments off.
module seg7_to_hex
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] hex_o,
    output logic       is_blank_o,
    output logic       is_legal_o
);

    // Table lookup of the glyph; anything not in the table is illegal.
    always_comb begin
        // NOTE: every output gets a value before the case, so no path can infer a latch.
        hex_o      = 4'h0;
        is_legal_o = 1'b1;
        is_blank_o = (seg_i == SEG_PAT_BLANK);
        case (seg_i)
            SEG_PAT_0: hex_o = 4'h0;
            SEG_PAT_1: hex_o = 4'h1;
            SEG_PAT_2: hex_o = 4'h2;
            SEG_PAT_3: hex_o = 4'h3;
            SEG_PAT_4: hex_o = 4'h4;
            SEG_PAT_5: hex_o = 4'h5;
            SEG_PAT_6: hex_o = 4'h6;
            SEG_PAT_7: hex_o = 4'h7;
            SEG_PAT_8: hex_o = 4'h8;
            SEG_PAT_9: hex_o = 4'h9;
            SEG_PAT_A: hex_o = 4'hA;
            SEG_PAT_B: hex_o = 4'hB;
            SEG_PAT_C: hex_o = 4'hC;
            SEG_PAT_D: hex_o = 4'hD;
            SEG_PAT_E: hex_o = 4'hE;
            SEG_PAT_F: hex_o = 4'hF;
            default:   is_legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Listening end of a 4-digit multiplexed 7-segment bus. Registers the bus,
// waits for each digit pattern to stay stable for STABLE_CNT samples, then
// latches its hex value, blank flag and (optionally) decimal point.
// Optional feature: define SEG_CAPTURE_DP_EN to include SEG_P in the stability
// compare and latch Dp; otherwise SEG_P is ignored and Dp reads 4'b0000.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int unsigned STABLE_CNT  = 4,
    parameter int unsigned TIMEOUT_CNT = 1024,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          DIG_ACT_LOW = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       SEG_D1,
    input  logic       SEG_D2,
    input  logic       SEG_D3,
    input  logic       SEG_D4,
    input  logic       SEG_A,
    input  logic       SEG_B,
    input  logic       SEG_C,
    input  logic       SEG_D,
    input  logic       SEG_E,
    input  logic       SEG_F,
    input  logic       SEG_G,
    input  logic       SEG_P,
    output logic [3:0] Dig0,
    output logic [3:0] Dig1,
    output logic [3:0] Dig2,
    output logic [3:0] Dig3,
    output logic [3:0] Valid,
    output logic [3:0] Blank,
    output logic [3:0] Dp,
    output logic       Frame_Done,
    output logic       Scan_Err
);

    localparam logic [3:0]  STABLE_MAX = 4'(STABLE_CNT);
    localparam logic [15:0] TO_MAX     = 16'(TIMEOUT_CNT);

`ifdef SEG_CAPTURE_DP_EN
    localparam int CMP_W = 8;
`else
    localparam int CMP_W = 7;
`endif

    // Registered, polarity-normalised bus sample.
    logic [3:0]       strobe_q;
    logic [6:0]       seg_q;
    logic [CMP_W-1:0] cur_pat;

    // Stability / timeout tracking.
    logic [3:0]       stab_cnt_q, stab_cnt_d;
    logic [15:0]      to_cnt_q, to_cnt_d;
    dig_idx_t         prev_idx_q;
    logic [CMP_W-1:0] prev_pat_q;

    // Output state.
    logic [3:0]       dig_q [4];
    logic [3:0]       dig_d [4];
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       blank_q, blank_d;
    logic [3:0]       mask_q, mask_d;
    logic             frame_done_q, frame_done_d;
    logic             scan_err_q, scan_err_d;

    strobe_kind_e     strobe_kind;
    dig_idx_t         strobe_idx;
    logic             latch_fire;
    logic             timeout_hit;
    logic             multi_err;
    logic [3:0]       dec_hex;
    logic             dec_blank;
    logic             dec_legal;

    // Sample the bus once and normalise to 1 = lit / active.
    always_ff @(posedge Clk or posedge Rst) begin
        // NOTE: clocked blocks use <= so every register sees the pre-edge values of the others.
        if (Rst) begin
            strobe_q <= '0;
            seg_q    <= '0;
        end else begin
            strobe_q <= {SEG_D4, SEG_D3, SEG_D2, SEG_D1} ^ {4{DIG_ACT_LOW}};
            seg_q    <= {SEG_G, SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A} ^ {7{SEG_ACT_LOW}};
        end
    end

`ifdef SEG_CAPTURE_DP_EN
    logic       dp_q;
    logic [3:0] dp_out_q, dp_out_d;

    // Decimal point sample and per-digit latched Dp.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            dp_q     <= 1'b0;
            dp_out_q <= '0;
        end else begin
            dp_q     <= SEG_P ^ SEG_ACT_LOW;
            dp_out_q <= dp_out_d;
        end
    end

    // Dp follows DigN: updated only when a decodable or blank pattern latches.
    always_comb begin
        dp_out_d = dp_out_q;
        if (latch_fire && (dec_legal || dec_blank)) begin
            dp_out_d[strobe_idx] = dp_q;
        end
    end

    assign cur_pat = {dp_q, seg_q};
    assign Dp      = dp_out_q;
`else
    logic unused_seg_p;
    assign unused_seg_p = SEG_P;
    assign cur_pat      = seg_q;
    assign Dp           = 4'b0000;
`endif

    // Classify the strobe sample: none, exactly one (with its index), or several.
    always_comb begin
        strobe_kind = STB_ONE;
        strobe_idx  = 2'd0;
        case (strobe_q)
            4'b0000: strobe_kind = STB_NONE;
            4'b0001: strobe_idx  = 2'd0;
            4'b0010: strobe_idx  = 2'd1;
            4'b0100: strobe_idx  = 2'd2;
            4'b1000: strobe_idx  = 2'd3;
            default: strobe_kind = STB_MULTI;
        endcase
    end

    seg7_to_hex u_decode (
        .seg_i      (seg_q),
        .hex_o      (dec_hex),
        .is_blank_o (dec_blank),
        .is_legal_o (dec_legal)
    );

    // Stability and timeout counters; decide when a latch or timeout fires.
    always_comb begin
        stab_cnt_d  = stab_cnt_q;
        to_cnt_d    = to_cnt_q;
        latch_fire  = 1'b0;
        timeout_hit = 1'b0;
        multi_err   = 1'b0;
        case (strobe_kind)
            STB_NONE: begin
                stab_cnt_d = '0;
                if (to_cnt_q != TO_MAX) begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
                timeout_hit = (to_cnt_d == TO_MAX);
            end
            STB_MULTI: begin
                stab_cnt_d = '0;
                multi_err  = 1'b1;
            end
            default: begin
                to_cnt_d = '0;
                if ((strobe_idx == prev_idx_q) && (cur_pat == prev_pat_q)) begin
                    if (stab_cnt_q != STABLE_MAX) begin
                        stab_cnt_d = stab_cnt_q + 4'd1;
                    end
                end else begin
                    stab_cnt_d = 4'd1;
                end
                // Fire only on the step into STABLE_MAX, once per stable run.
                latch_fire = (stab_cnt_d == STABLE_MAX) && (stab_cnt_q != STABLE_MAX);
            end
        endcase
    end

    // Output next-state: latch results, frame mask, Frame_Done and sticky error.
    always_comb begin
        dig_d        = dig_q;
        valid_d      = valid_q;
        blank_d      = blank_q;
        frame_done_d = (mask_q == 4'hF);
        mask_d       = frame_done_d ? 4'h0 : mask_q;
        scan_err_d   = scan_err_q | multi_err;
        if (timeout_hit) begin
            valid_d = '0;
            mask_d  = '0;
        end
        if (latch_fire) begin
            mask_d[strobe_idx] = 1'b1;
            if (dec_legal) begin
                dig_d[strobe_idx]   = dec_hex;
                valid_d[strobe_idx] = 1'b1;
                blank_d[strobe_idx] = 1'b0;
            end else if (dec_blank) begin
                dig_d[strobe_idx]   = 4'h0;
                valid_d[strobe_idx] = 1'b1;
                blank_d[strobe_idx] = 1'b1;
            end else begin
                valid_d[strobe_idx] = 1'b0;
                scan_err_d          = 1'b1;
            end
        end
    end

    // State registers for counters, compare history and outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stab_cnt_q   <= '0;
            to_cnt_q     <= '0;
            prev_idx_q   <= '0;
            prev_pat_q   <= '0;
            dig_q        <= '{default: 4'h0};
            valid_q      <= '0;
            blank_q      <= '0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
            scan_err_q   <= 1'b0;
        end else begin
            stab_cnt_q   <= stab_cnt_d;
            to_cnt_q     <= to_cnt_d;
            prev_idx_q   <= strobe_idx;
            prev_pat_q   <= cur_pat;
            dig_q        <= dig_d;
            valid_q      <= valid_d;
            blank_q      <= blank_d;
            mask_q       <= mask_d;
            frame_done_q <= frame_done_d;
            scan_err_q   <= scan_err_d;
        end
    end

    assign Dig0       = dig_q[0];
    assign Dig1       = dig_q[1];
    assign Dig2       = dig_q[2];
    assign Dig3       = dig_q[3];
    assign Valid      = valid_q;
    assign Blank      = blank_q;
    assign Frame_Done = frame_done_q;
    assign Scan_Err   = scan_err_q;

endmodule
